// File: rtl/d_m_flit_upload_if.sv
// rtl/d_m_flit_upload_if.sv - dcache-to-ring upload handshake bundle (message in, flit stream out)
// UPLOAD_PARITY_EN adds flit_parity and msg_parity.
interface d_m_flit_upload_if #(
  parameter int MSG_W  = 144,
  parameter int FLIT_W = 16
);
  logic [MSG_W-1:0]  d_m_msg;
  logic              v_d_m_msg;
  logic              flit_ready;
  logic [FLIT_W-1:0] flit_out;
  logic              v_flit_out;
  logic [1:0]        flit_ctrl;
  logic              d_m_upload_state;
  logic              upload_done;
`ifdef UPLOAD_PARITY_EN
  logic              flit_parity;
  logic              msg_parity;

  modport master (
    output d_m_msg, v_d_m_msg, flit_ready,
    input  flit_out, v_flit_out, flit_ctrl, d_m_upload_state, upload_done,
    input  flit_parity, msg_parity
  );

  modport slave (
    input  d_m_msg, v_d_m_msg, flit_ready,
    output flit_out, v_flit_out, flit_ctrl, d_m_upload_state, upload_done,
    output flit_parity, msg_parity
  );
`else
  modport master (
    output d_m_msg, v_d_m_msg, flit_ready,
    input  flit_out, v_flit_out, flit_ctrl, d_m_upload_state, upload_done
  );

  modport slave (
    input  d_m_msg, v_d_m_msg, flit_ready,
    output flit_out, v_flit_out, flit_ctrl, d_m_upload_state, upload_done
  );
`endif
endinterface

// File: rtl/d_m_flit_upload.sv
// rtl/d_m_flit_upload.sv - latches one dcache-to-memory message and serializes it as MSB-first ring flits
// Optional UPLOAD_PARITY_EN: per-flit even parity and whole-message XOR status.
module d_m_flit_upload #(
  parameter int MSG_W     = 144,
  parameter int FLIT_W    = 16,
  parameter int NUM_FLITS = MSG_W / FLIT_W
) (
  input  logic             clk,
  input  logic             rst,
  d_m_flit_upload_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_FLITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FLITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [FLIT_W-1:0] flit_sel;

  // Explicit compare per slot keeps the mux in range even for counter codes above LAST.
  always_comb begin
    flit_sel = '0;
    for (int i = 0; i < NUM_FLITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        flit_sel = msg_q[MSG_W-1-i*FLIT_W -: FLIT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.v_d_m_msg) begin
          msg_d   = bus.d_m_msg;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Message input is deliberately ignored here; the cache must gate on d_m_upload_state.
        if (bus.flit_ready) begin
          if (cnt_q != LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.v_flit_out       = (state_q == SEND);
  assign bus.d_m_upload_state = (state_q == SEND);
  assign bus.flit_out         = (state_q == SEND) ? flit_sel : '0;
  assign bus.flit_ctrl        = (state_q == SEND) ? {cnt_q == '0, cnt_q == LAST} : 2'b00;
  assign bus.upload_done      = done_q;

`ifdef UPLOAD_PARITY_EN
  logic par_q, par_d;

  // Running XOR of accepted flits; holds its final value through the done cycle until the next capture.
  always_comb begin
    par_d = par_q;
    if (state_q == IDLE && bus.v_d_m_msg) begin
      par_d = 1'b0;
    end else if (state_q == SEND && bus.flit_ready) begin
      par_d = par_q ^ (^flit_sel);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.flit_parity = (state_q == SEND) ? ^flit_sel : 1'b0;
  assign bus.msg_parity  = par_q;
`endif

endmodule

// File: doc/d_m_flit_upload.md
Name: d_m_flit_upload

Overview:
- Transmit-side counterpart of the memory-to-dcache arrival register.
- Accepts one 144-bit data-cache-to-memory message in a single cycle, latches it, and serializes it onto the ring injection port as 16-bit flits with a valid/ready handshake.
- Reports busy to the data cache so the cache never overwrites a message still in flight.
- Emits a one-cycle done pulse after the tail flit is accepted.

Parameters:
- MSG_W, 144: message width in bits.
- FLIT_W, 16: flit width in bits.
- NUM_FLITS, 9: flits per message (MSG_W/FLIT_W); counter width is clog2(NUM_FLITS).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- d_m_msg  input  MSG_W  message from data cache.
- v_d_m_msg  input  1  message valid; sampled only in IDLE.
- flit_ready  input  1  ring arbiter accepts the current flit this cycle.
- flit_out  output  FLIT_W  current flit.
- v_flit_out  output  1  flit_out is valid.
- flit_ctrl  output  2  bit1 = head (flit 0), bit0 = tail (flit NUM_FLITS-1).
- d_m_upload_state  output  1  1 = busy, cannot accept a message.
- upload_done  output  1  one-cycle pulse after the tail handshake.

Behaviour:
- Reset: while rst=0, all state is cleared immediately and asynchronously.
  - FSM=IDLE, msg_reg=0, cnt=0.
  - v_flit_out=0, flit_out=0, flit_ctrl=0, d_m_upload_state=0, upload_done=0.
- FSM states:
  - IDLE:
    - v_d_m_msg=1 → next edge: msg_reg<=d_m_msg, cnt<=0, go to SEND.
    - v_d_m_msg=0 → stay in IDLE.
  - SEND:
    - v_flit_out=1.
    - flit_out = msg_reg[MSG_W-1-cnt*FLIT_W -: FLIT_W] (MSB slice first).
    - On each edge with flit_ready=1: if cnt<NUM_FLITS-1 then cnt++; else go to IDLE, cnt<=0, upload_done<=1.
    - flit_ready=0 → hold cnt and flit_out stable (no skipped or repeated flit).
- Outputs:
  - All outputs are registered-state derived: flit_out, v_flit_out, flit_ctrl and d_m_upload_state are combinational from FSM/cnt/msg_reg. No combinational path from any input to any output.
  - d_m_upload_state = (FSM==SEND).
  - flit_ctrl = {cnt==0, cnt==NUM_FLITS-1} in SEND; 2'b00 in IDLE.
  - upload_done: registered, high exactly one cycle, in the first IDLE cycle after the tail handshake.
- Latency and throughput:
  - Message capture to first valid flit: 1 cycle.
  - Full message with flit_ready held at 1: NUM_FLITS cycles in SEND.
  - Back-to-back messages: a new v_d_m_msg is accepted in the IDLE cycle where upload_done=1, so the minimum spacing is NUM_FLITS+1 cycles.
- Boundary conditions:
  - v_d_m_msg during SEND: ignored; msg_reg unchanged. Upstream must gate on d_m_upload_state.
  - flit_ready while IDLE: ignored.
  - Reset asserted mid-message: message is dropped, no done pulse, outputs clear at once.
  - Reset release: first capture is possible on the first edge after rst=1.
- Counter never exceeds NUM_FLITS-1; wrap to 0 happens only via the tail transition.

Optional Feature:
- Macro: UPLOAD_PARITY_EN.
- Defined:
  - Adds output port flit_parity (1 bit) = even parity (XOR) of flit_out while v_flit_out=1; 0 otherwise.
  - Adds a registered status bit that captures the XOR of all flits, exposed as output msg_parity. msg_parity is cleared on capture and valid while upload_done=1.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles → all outputs 0. Release with no stimulus → d_m_upload_state stays 0, v_flit_out stays 0.
2. Single message, flit_ready=1: d_m_msg=144'h0001_0002_..._0009 → flits 16'h0001..16'h0009 on 9 consecutive cycles; flit_ctrl=2'b10 on flit 0, 2'b01 on flit 8; upload_done=1 for exactly 1 cycle after.
3. Backpressure: flit_ready=0 for 4 cycles at cnt=3 → flit_out holds 16'h0004, cnt holds. Release → flit 16'h0005 follows; exactly 9 handshakes total.
4. Busy collision: second v_d_m_msg=1 (msg 144'hFFFF...) at cnt=5 → ignored; remaining flits still come from the first message. Re-present in the upload_done cycle → accepted; next flit 0 = 16'hFFFF.
5. Reset mid-send: rst=0 asynchronously at cnt=6 → v_flit_out and d_m_upload_state drop without waiting for a clock edge; no upload_done. After release, a new message starts at flit 0.
6. With UPLOAD_PARITY_EN defined: flit 16'h0007 → flit_parity=1; flit 16'h0003 → flit_parity=0. msg_parity equals the reference XOR of all 9 flits during upload_done.
